imem_boot_loader: RTL and testbench

//  Sequences program load into the 64x32 instruction memory before the core runs.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_boot_loader_byte_packer.sv | 36 +++
 rtl/imem_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
// The checksum option is enabled with `define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned LEN_W      = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words.
// o_word_c includes the byte being accepted this cycle.
module imem_boot_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_full_c
);

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_word;

  always_comb begin
    o_word_c = r_word;
    o_word_c[BYTE_W*r_cnt +: BYTE_W] = i_byte;
  end

  assign o_word_full_c = i_accept && (r_cnt == CNT_W'(WORD_BYTES - 1));

  // Counter wraps to zero on the 4th byte, ready for the next word.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_word <= o_word_c;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte-streamed program image into imem and holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word after the image.
module imem_boot_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [WORD_W-1:0] wa,
  output logic [WORD_W-1:0] wd,
  output logic              busy,
  output logic              done,
  output logic              cpu_reset,
  output logic              error
);

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt, w_len_clamp;
  logic [ADDR_W-1:0] r_word_idx, w_idx_nxt;
  logic              r_byte_ready, r_we, r_busy, r_done, r_cpu_reset;
  logic [WORD_W-1:0] r_wa, r_wd, w_wa_nxt, w_wd_nxt, w_word;
  logic              w_accept, w_last, w_clear, w_word_full, w_can_start;

  assign w_accept    = byte_valid && r_byte_ready;
  assign w_len_clamp = (len_words > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_words;
  assign w_last      = ({1'b0, r_word_idx} == (r_len - LEN_W'(1)));
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);

  imem_boot_loader_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_clear),
    .i_accept      (w_accept),
    .i_byte        (byte_in),
    .o_word_c      (w_word),
    .o_word_full_c (w_word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              r_trailer, w_trailer_nxt, r_error;
  logic [WORD_W-1:0] r_sum, w_sum_nxt, r_chk_word, w_chk_nxt;
`endif

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_word_idx;
    w_clear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_trailer_nxt = r_trailer;
    w_sum_nxt     = r_sum;
    w_chk_nxt     = r_chk_word;
`endif
    case (r_state)
      ST_RECV: begin
        if (w_word_full) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (r_trailer) begin
            w_chk_nxt   = w_word;
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_WRITE;
          end
`else
          w_state_nxt = ST_WRITE;
`endif
        end
      end
      ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_sum_nxt = r_sum + r_wd;
`endif
        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_trailer_nxt = 1'b1;
          w_state_nxt   = ST_RECV;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_idx_nxt   = r_word_idx + ADDR_W'(1);
          w_state_nxt = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: w_state_nxt = (r_chk_word == r_sum) ? ST_DONE : ST_ERR;
`endif
      default: ;
    endcase
    // Start is honoured only when no load is in flight.
    if (start && w_can_start) begin
      w_clear     = 1'b1;
      w_len_nxt   = w_len_clamp;
      w_idx_nxt   = '0;
      w_state_nxt = (w_len_clamp == '0) ? ST_DONE : ST_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
      w_trailer_nxt = 1'b0;
      w_sum_nxt     = '0;
`endif
    end
    w_wa_nxt = r_wa;
    w_wd_nxt = r_wd;
    if (w_state_nxt == ST_WRITE) begin
      w_wa_nxt = WORD_W'({w_idx_nxt, 2'b00});
      w_wd_nxt = w_word;
    end
  end

  // State register; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_reset  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_trailer    <= 1'b0;
      r_sum        <= '0;
      r_chk_word   <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_word_idx   <= w_idx_nxt;
      r_byte_ready <= (w_state_nxt == ST_RECV);
      r_we         <= (w_state_nxt == ST_WRITE);
      r_wa         <= w_wa_nxt;
      r_wd         <= w_wd_nxt;
      r_busy       <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE) ||
                      (w_state_nxt == ST_CHECK);
      r_done       <= (w_state_nxt == ST_DONE);
      r_cpu_reset  <= (w_state_nxt != ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_trailer    <= w_trailer_nxt;
      r_sum        <= w_sum_nxt;
      r_chk_word   <= w_chk_nxt;
      r_error      <= (w_state_nxt == ST_ERR);
`endif
    end
  end

  assign byte_ready = r_byte_ready;
  assign we         = r_we;
  assign wa         = r_wa;
  assign wd         = r_wd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cpu_reset  = r_cpu_reset;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error      = r_error;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of loads plus hand-written corner sequences.
// Works in both builds; checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_boot_loader;
  import imem_loader_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, byte_valid;
  logic [LEN_W-1:0]  len_words;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_ready, we, busy, done, cpu_reset, error;
  logic [WORD_W-1:0] wa, wd;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic [63:0] got_q[$];

  imem_boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_words  (len_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .busy       (busy),
    .done       (done),
    .cpu_reset  (cpu_reset),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write-port and ready monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) got_q.push_back({wa, wd});
    if (byte_ready) ready_cnt++;
  end

  typedef struct {
    int          len;
    int          gap;
    int          exp_writes;
    logic [31:0] exp_last_wa;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = LEN_W'(len);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Offer one byte; gap=1 drops valid for a cycle first.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    if (gap != 0) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  // Full load: model expects min(len,DEPTH) writes at wa=4*i with the source words.
  task automatic run_load(input int len, input int gap, input int bad, input logic [31:0] src[$],
                          output int nwr, output logic [31:0] last_wa);
    int n;
    int base;
    int budget;
    logic [31:0] words[$];
    logic [31:0] sum;
    n    = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    sum  = '0;
    for (int i = 0; i < n; i++) words.push_back((i < src.size()) ? src[i] : $urandom);
    base = got_q.size();
    do_start(len);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    for (int i = 0; i < n; i++) begin
      send_word(words[i], gap);
      sum = sum + words[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum + 32'(bad), gap);
`else
    chk("last_we_latency", {31'd0, we}, 32'd1);
    chk("done_not_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("done_latency", {31'd0, done}, 32'd1);
    chk("cpu_release_latency", {31'd0, cpu_reset}, 32'd0);
`endif
    budget = 0;
    while (!done && !error && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (bad != 0) begin
      chk("err_flag", {31'd0, error}, 32'd1);
      chk("err_done", {31'd0, done}, 32'd0);
      chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end else begin
      chk("done_flag", {31'd0, done}, 32'd1);
      chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("done_error", {31'd0, error}, 32'd0);
    end
    chk("done_busy", {31'd0, busy}, 32'd0);
    nwr = got_q.size() - base;
    chk("write_count", 32'(nwr), 32'(n));
    last_wa = (nwr > 0) ? got_q[got_q.size()-1][63:32] : 32'hFFFF_FFFF;
    for (int i = 0; i < n && i < nwr; i++) begin
      chk("write_addr", got_q[base+i][63:32], 32'(4*i));
      chk("write_data", got_q[base+i][31:0], words[i]);
    end
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] src[$];
    logic [31:0] none[$];
    int          nwr, rc, base;
    logic [31:0] lwa;

    vecs[0] = '{len: 1,   gap: 0, exp_writes: 1,  exp_last_wa: 32'h00};
    vecs[1] = '{len: 3,   gap: 1, exp_writes: 3,  exp_last_wa: 32'h08};
    vecs[2] = '{len: 7,   gap: 0, exp_writes: 7,  exp_last_wa: 32'h18};
    vecs[3] = '{len: 100, gap: 0, exp_writes: 64, exp_last_wa: 32'hFC};
    vecs[4] = '{len: 64,  gap: 1, exp_writes: 64, exp_last_wa: 32'hFC};
    vecs[5] = '{len: 65,  gap: 0, exp_writes: 64, exp_last_wa: 32'hFC};
    vecs[6] = '{len: 5,   gap: 1, exp_writes: 5,  exp_last_wa: 32'h10};

    reset = 1'b1; start = 1'b0; len_words = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_error", {31'd0, error}, 32'd0);

    // Reference image from the datasheet example.
    src = {32'h1234_5678, 32'hDEAD_BEEF};
    run_load(2, 0, 0, src, nwr, lwa);
    chk("example_last_wa", lwa, 32'h4);

    // Zero-length load completes without touching imem or the stream.
    rc = ready_cnt;
    base = got_q.size();
    do_start(0);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    repeat (3) @(negedge clk);
    chk("len0_no_write", 32'(got_q.size() - base), 32'd0);
    chk("len0_no_ready", 32'(ready_cnt - rc), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_load(vecs[v].len, vecs[v].gap, 0, none, nwr, lwa);
      chk("vec_writes", 32'(nwr), 32'(vecs[v].exp_writes));
      chk("vec_last_wa", lwa, vecs[v].exp_last_wa);
    end

    // Reset after 5 of 8 bytes: abort with no further write, then reload cleanly.
    base = got_q.size();
    do_start(2);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
    chk("abort_pre_writes", 32'(got_q.size() - base), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("abort_ready", {31'd0, byte_ready}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(got_q.size() - base), 32'd1);
    run_load(2, 0, 0, none, nwr, lwa);

`ifdef IMEM_LOADER_CHECKSUM_EN
    src = {32'h0000_0001};
    run_load(1, 0, 0, src, nwr, lwa);
    run_load(1, 0, 1, src, nwr, lwa);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, error}, 32'd1);
    run_load(3, 1, 0, none, nwr, lwa);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
